// File: rtl/asi_pkg.sv
// Shared types and constants for the ASI master poll scheduler.
// Holds the scheduler state encoding and the request-word layout helper.
package asi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SELECT,
      FETCH,
      SEND,
      WAIT_RESP,
      GAP
   } asi_state_t;

   localparam int ASI_TX_TICKS     = 28;
   localparam int ASI_ADDR_W       = 5;
   localparam int ASI_REQ_ADDR_LSB = 8;

   // Data request: start bit and SB stay 0, address and output nibble in place.
   function automatic logic [15:0] asi_req_word(input logic [ASI_ADDR_W-1:0] addr,
                                                input logic [3:0]            nib);
      logic [15:0] w;
      w = '0;
      w[ASI_REQ_ADDR_LSB +: ASI_ADDR_W] = addr;
      w[3:0] = nib;
      return w;
   endfunction

endpackage

// File: rtl/asi_next_slave.sv
// Sequential round-robin search over the projected-slave list, one address
// per cycle, starting just after start_addr and wrapping from 31 back to 1.
module asi_next_slave
   import asi_pkg::*;
(
   input  logic                  clk_in,
   input  logic                  rst,
   input  logic                  search,
   input  logic [ASI_ADDR_W-1:0] start_addr,
   input  logic [31:0]           lps,
   output logic                  hit,
   output logic [ASI_ADDR_W-1:0] hit_addr,
   output logic                  wrap
);

   logic                  active;
   logic [ASI_ADDR_W-1:0] ptr;
   logic [ASI_ADDR_W-1:0] base;
   logic [ASI_ADDR_W-1:0] cand;

   // The first probe of a search continues from the served slave, later probes from ptr.
   assign base     = active ? ptr : start_addr;
   assign cand     = (base == 5'd31) ? 5'd1 : base + 5'd1;
   assign hit      = search && lps[cand];
   assign hit_addr = cand;
   assign wrap     = search && (base == 5'd31);

   always_ff @(posedge clk_in) begin
      if (rst) begin
         active <= 1'b0;
         ptr    <= '0;
      end else if (search) begin
         active <= !hit;
         ptr    <= cand;
      end else begin
         active <= 1'b0;
      end
   end

endmodule

// File: rtl/asi_poll_scheduler.sv
// ASI master transaction sequencer: round-robin slave polling, request framing,
// response window timing with retry, and maintenance of the activated-slave list.
module asi_poll_scheduler
   import asi_pkg::*;
#(
   parameter int TX_TICKS     = ASI_TX_TICKS,
   parameter int RESP_TIMEOUT = 40,
   parameter int GAP_TICKS    = 4,
   parameter int MAX_TRIES    = 2
) (
   input  logic        clk_in,
   input  logic        rst,
   input  logic        tick_3us,
   input  logic        enable,
   input  logic [31:0] lps,
   output logic [4:0]  out_rd_addr,
   input  logic [3:0]  out_rd_data,
   output logic        req_flag,
   output logic [15:0] req_data,
   input  logic        resp_valid,
   input  logic        resp_ok,
   input  logic [3:0]  resp_data,
   output logic        in_wr_en,
   output logic [4:0]  in_wr_addr,
   output logic [3:0]  in_wr_data,
   output logic [31:0] las,
   output logic [4:0]  cur_addr,
   output logic        busy,
   output logic        cycle_done
);

   asi_state_t            state;
   asi_state_t            state_nx;
   logic [5:0]            cnt;
   logic [5:0]            cnt_p1;
   logic [3:0]            try_cnt;
   logic                  retry;
   logic                  lps_nz;
   logic                  sel_hit;
   logic                  sel_wrap;
   logic [ASI_ADDR_W-1:0] sel_addr;
   logic                  rsp_good;
   logic                  rsp_fail;

   assign lps_nz     = |lps[31:1];
   assign cnt_p1     = cnt + 6'd1;
   assign busy       = (state != IDLE);
   assign cycle_done = sel_wrap && lps_nz;

   asi_next_slave u_next_slave (
      .clk_in     (clk_in),
      .rst        (rst),
      .search     (state == SELECT),
      .start_addr (cur_addr),
      .lps        (lps),
      .hit        (sel_hit),
      .hit_addr   (sel_addr),
      .wrap       (sel_wrap)
   );

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      rsp_good = 1'b0;
      rsp_fail = 1'b0;
      case (state)
         IDLE: begin
            if (enable && lps_nz) state_nx = SELECT;
         end
         SELECT: begin
            if (!lps_nz)      state_nx = IDLE;
            else if (sel_hit) state_nx = FETCH;
         end
         FETCH: begin
            state_nx = SEND;
         end
         SEND: begin
            if (tick_3us && cnt_p1 == 6'(TX_TICKS)) state_nx = WAIT_RESP;
         end
         WAIT_RESP: begin
            // A response landing on the timeout tick takes priority over the timeout.
            if (resp_valid && resp_ok) begin
               rsp_good = 1'b1;
            end else if (resp_valid || (tick_3us && cnt_p1 == 6'(RESP_TIMEOUT))) begin
               rsp_fail = 1'b1;
            end
            if (rsp_good || rsp_fail) state_nx = GAP;
         end
         GAP: begin
            if (tick_3us && cnt_p1 == 6'(GAP_TICKS)) begin
               if (retry)       state_nx = FETCH;
               else if (enable) state_nx = SELECT;
               else             state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         cnt         <= '0;
         try_cnt     <= '0;
         retry       <= 1'b0;
         cur_addr    <= '0;
         out_rd_addr <= '0;
         req_flag    <= 1'b0;
         req_data    <= '0;
         in_wr_en    <= 1'b0;
         in_wr_addr  <= '0;
         in_wr_data  <= '0;
         las         <= '0;
      end else begin
         in_wr_en <= 1'b0;
         // Every state boundary restarts the tick count.
         if (state_nx != state) begin
            cnt <= '0;
         end else if (tick_3us) begin
            cnt <= cnt_p1;
         end
         case (state)
            SELECT: begin
               las <= las & {lps[31:1], 1'b0};
               if (lps_nz && sel_hit) begin
                  cur_addr    <= sel_addr;
                  out_rd_addr <= sel_addr;
                  try_cnt     <= '0;
                  retry       <= 1'b0;
               end
            end
            FETCH: begin
               req_data <= asi_req_word(cur_addr, out_rd_data);
               req_flag <= 1'b1;
            end
            SEND: begin
               if (tick_3us && cnt_p1 == 6'(TX_TICKS / 2)) req_flag <= 1'b0;
            end
            WAIT_RESP: begin
               if (rsp_good) begin
                  in_wr_en       <= 1'b1;
                  in_wr_addr     <= cur_addr;
                  in_wr_data     <= resp_data;
                  las[cur_addr]  <= 1'b1;
                  retry          <= 1'b0;
               end else if (rsp_fail) begin
                  if (try_cnt + 4'd1 < 4'(MAX_TRIES)) begin
                     try_cnt <= try_cnt + 4'd1;
                     retry   <= 1'b1;
                  end else begin
                     las[cur_addr] <= 1'b0;
                     retry         <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_asi_poll_scheduler.sv
// Bench for asi_poll_scheduler: directed phases plus a randomized phase, all
// compared against a transaction-level reference model of the poll schedule.
module tb_asi_poll_scheduler;

   localparam int TDIV   = 3;
   localparam int K_GOOD = 0;
   localparam int K_BAD  = 1;
   localparam int K_NONE = 2;
   localparam int K_EDGE = 3;

   logic        clk_in = 1'b0;
   logic        rst;
   logic        tick_3us;
   logic        enable;
   logic [31:0] lps;
   logic [4:0]  out_rd_addr;
   logic [3:0]  out_rd_data;
   logic        req_flag;
   logic [15:0] req_data;
   logic        resp_valid;
   logic        resp_ok;
   logic [3:0]  resp_data;
   logic        in_wr_en;
   logic [4:0]  in_wr_addr;
   logic [3:0]  in_wr_data;
   logic [31:0] las;
   logic [4:0]  cur_addr;
   logic        busy;
   logic        cycle_done;

   logic [3:0]  out_img [32];
   assign out_rd_data = out_img[out_rd_addr];

   always #5 clk_in = ~clk_in;

   asi_poll_scheduler dut (
      .clk_in      (clk_in),
      .rst         (rst),
      .tick_3us    (tick_3us),
      .enable      (enable),
      .lps         (lps),
      .out_rd_addr (out_rd_addr),
      .out_rd_data (out_rd_data),
      .req_flag    (req_flag),
      .req_data    (req_data),
      .resp_valid  (resp_valid),
      .resp_ok     (resp_ok),
      .resp_data   (resp_data),
      .in_wr_en    (in_wr_en),
      .in_wr_addr  (in_wr_addr),
      .in_wr_data  (in_wr_data),
      .las         (las),
      .cur_addr    (cur_addr),
      .busy        (busy),
      .cycle_done  (cycle_done)
   );

   int checks = 0;
   int errors = 0;

   // Monitor state
   logic        prev_flag = 1'b0;
   int          tsr = 0;
   int          ft_cur = 0;
   int          last_ft = 0;
   int          cd_cnt = 0;
   int          tick_ph = 0;
   logic [15:0] rq [$];
   logic [8:0]  wq [$];
   logic [15:0] scratch;

   // Reference model state
   int          m_cur = 0;
   int          m_try = 0;
   logic        m_retry = 1'b0;
   logic [31:0] m_las = '0;
   int          m_cd = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic finish_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   endtask

   // Sample the current cycle, advance one clock, then set default inputs.
   task automatic step();
      if (req_flag && !prev_flag) begin
         rq.push_back(req_data);
         tsr    = tick_3us ? 1 : 0;
         ft_cur = 0;
      end else if (tick_3us) begin
         tsr++;
      end
      if (req_flag && tick_3us) ft_cur++;
      if (!req_flag && prev_flag) last_ft = ft_cur;
      prev_flag = req_flag;
      if (in_wr_en) wq.push_back({in_wr_addr, in_wr_data});
      if (cycle_done) cd_cnt++;
      @(posedge clk_in);
      #1;
      tick_ph    = (tick_ph + 1) % TDIV;
      tick_3us   = (tick_ph == 0);
      resp_valid = 1'b0;
   endtask

   task automatic wait_rise();
      int n = 0;
      while (rq.size() == 0 && n < 5000) begin
         step();
         n++;
      end
      chk("wait_request", 32'(rq.size() != 0), 32'd1);
      if (rq.size() == 0) finish_run();
   endtask

   // Returns in the cycle carrying the target-th tick since the request began.
   task automatic wait_tick(input int target);
      int n = 0;
      while (!(tick_3us && tsr + 1 == target) && n < 1000) begin
         step();
         n++;
      end
      chk("wait_tick", 32'(tick_3us && tsr + 1 == target), 32'd1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 3000) begin
         step();
         n++;
      end
      chk("idle", 32'(busy), 32'd0);
   endtask

   // Next polled slave: lowest projected address above cur, else lowest overall.
   function automatic int next_addr(input int cur);
      int lowest;
      int above;
      lowest = 0;
      above  = 0;
      for (int i = 31; i >= 1; i--) begin
         if (lps[i]) begin
            lowest = i;
            if (i > cur) above = i;
         end
      end
      return (above != 0) ? above : lowest;
   endfunction

   task automatic txn(input int kind, input logic [3:0] rdata, input logic drop_en);
      int          a;
      logic [15:0] w;
      logic [8:0]  wr;
      if (m_retry) begin
         a = m_cur;
      end else begin
         a = next_addr(m_cur);
         if (a <= m_cur) m_cd++;
         m_cur = a;
         m_try = 0;
      end
      wait_rise();
      w = rq.pop_front();
      chk("req_addr", 32'(w[12:8]), 32'(a));
      chk("req_word", 32'(w), 32'({3'b000, 5'(a), 4'b0000, out_img[a]}));
      chk("las", las, m_las);
      chk("cycle_done_count", 32'(cd_cnt), 32'(m_cd));
      chk("stray_write", 32'(wq.size()), 32'd0);
      chk("busy_active", 32'(busy), 32'd1);
      if (drop_en) enable = 1'b0;
      if (kind == K_GOOD && $urandom_range(0, 1) == 1) begin
         wait_tick($urandom_range(2, 19));
         resp_valid = 1'b1;
         resp_ok    = 1'b1;
         resp_data  = ~rdata;
         step();
      end
      wait_tick(20);
      chk("flag_ticks", 32'(last_ft), 32'd14);
      if (kind == K_GOOD || kind == K_BAD) begin
         wait_tick($urandom_range(29, 67));
         resp_valid = 1'b1;
         resp_ok    = (kind == K_GOOD);
         resp_data  = rdata;
         step();
      end else if (kind == K_EDGE) begin
         wait_tick(68);
         resp_valid = 1'b1;
         resp_ok    = 1'b1;
         resp_data  = rdata;
         step();
      end
      if (kind == K_GOOD || kind == K_EDGE) begin
         step();
         step();
         chk("write_count", 32'(wq.size()), 32'd1);
         if (wq.size() != 0) begin
            wr = wq.pop_front();
            chk("write_entry", 32'(wr), 32'({5'(a), rdata}));
         end
         m_las[a] = 1'b1;
         m_retry  = 1'b0;
      end else if (m_try + 1 < 2) begin
         m_try++;
         m_retry = 1'b1;
      end else begin
         m_las[a] = 1'b0;
         m_retry  = 1'b0;
      end
   endtask

   task automatic start_phase(input logic [31:0] new_lps);
      lps    = new_lps;
      m_las  = m_las & new_lps & 32'hFFFF_FFFE;
      enable = 1'b1;
   endtask

   task automatic end_phase();
      enable = 1'b0;
      wait_idle();
      repeat (3) step();
      chk("phase_las", las, m_las);
      chk("phase_writes", 32'(wq.size()), 32'd0);
      chk("phase_requests", 32'(rq.size()), 32'd0);
      chk("phase_cycle_done", 32'(cd_cnt), 32'(m_cd));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_req_flag"}, 32'(req_flag), 32'd0);
      chk({tag, "_req_data"}, 32'(req_data), 32'd0);
      chk({tag, "_in_wr_en"}, 32'(in_wr_en), 32'd0);
      chk({tag, "_in_wr_addr"}, 32'(in_wr_addr), 32'd0);
      chk({tag, "_in_wr_data"}, 32'(in_wr_data), 32'd0);
      chk({tag, "_las"}, las, 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_cycle_done"}, 32'(cycle_done), 32'd0);
      chk({tag, "_cur_addr"}, 32'(cur_addr), 32'd0);
      chk({tag, "_out_rd_addr"}, 32'(out_rd_addr), 32'd0);
   endtask

   initial begin
      logic [31:0] rl;
      int          kind;
      rst        = 1'b1;
      enable     = 1'b0;
      lps        = '0;
      tick_3us   = 1'b0;
      resp_valid = 1'b0;
      resp_ok    = 1'b0;
      resp_data  = '0;
      for (int i = 0; i < 32; i++) out_img[i] = 4'($urandom);

      // Reset values, then idle with an empty slave list.
      repeat (3) step();
      chk_all_zero("reset");
      rst    = 1'b0;
      enable = 1'b1;
      repeat (12) step();
      chk("idle_empty_lps_busy", 32'(busy), 32'd0);
      chk("idle_empty_lps_flag", 32'(req_flag), 32'd0);

      // Slaves 3 and 7, every attempt answered with 4'hA.
      start_phase(32'h0000_0088);
      for (int i = 0; i < 6; i++) txn(K_GOOD, 4'hA, 1'b0);
      end_phase();
      chk("las_3_7", las, 32'h0000_0088);
      chk("wraps_3_7", 32'(cd_cnt), 32'd2);

      // Slave 5: one good answer, then silence until dropped, then scanning resumes.
      start_phase(32'h0000_0020);
      txn(K_GOOD, 4'($urandom), 1'b0);
      txn(K_NONE, 4'h0, 1'b0);
      txn(K_NONE, 4'h0, 1'b0);
      txn(K_GOOD, 4'($urandom), 1'b0);
      end_phase();

      // Slave 9: bad parity first, good on the retry; enable dropped during that SEND.
      start_phase(32'h0000_0200);
      txn(K_BAD, 4'h0, 1'b0);
      txn(K_GOOD, 4'($urandom), 1'b1);
      end_phase();
      chk("las_9", 32'(las[9]), 32'd1);

      // Response on the timeout tick wins and causes no retry.
      start_phase(32'h0010_1000);
      txn(K_EDGE, 4'($urandom), 1'b0);
      txn(K_EDGE, 4'($urandom), 1'b0);
      txn(K_GOOD, 4'($urandom), 1'b0);
      end_phase();

      // Randomized slave list, output image and outcomes.
      for (int i = 0; i < 32; i++) out_img[i] = 4'($urandom);
      rl = $urandom & $urandom & $urandom & 32'hFFFF_FFFE;
      if (rl == 0) rl[$urandom_range(1, 31)] = 1'b1;
      start_phase(rl);
      for (int i = 0; i < 20; i++) begin
         kind = $urandom_range(0, 5);
         if (kind > K_EDGE) kind = K_GOOD;
         txn(kind, 4'($urandom), 1'b0);
      end
      while (m_retry) txn(K_GOOD, 4'($urandom), 1'b0);
      end_phase();

      // Reset while waiting for a response; a late response must be dropped.
      enable = 1'b1;
      wait_rise();
      if (rq.size() != 0) scratch = rq.pop_front();
      wait_tick(40);
      rst = 1'b1;
      step();
      chk_all_zero("abort");
      enable = 1'b0;
      rst    = 1'b0;
      step();
      resp_valid = 1'b1;
      resp_ok    = 1'b1;
      resp_data  = 4'h5;
      repeat (4) step();
      chk("late_resp_writes", 32'(wq.size()), 32'd0);
      chk("late_resp_busy", 32'(busy), 32'd0);
      chk("late_resp_las", las, 32'd0);

      finish_run();
   end

endmodule
